// File: rtl/pmbist_mem_checker.sv
// Per-memory response checker: delays expected data to the read latency, compares, and holds
// pass/fail results in a shift chain. Define PMBIST_CHK_DIAG_EN for first-fail diagnostics.
module pmbist_mem_checker #(
  parameter int unsigned BG_DATA    = 2,
  parameter int unsigned ADDR_X     = 2,
  parameter int unsigned ADDR_Y     = 2,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FAIL_CNT_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_mbist_run,
  input  logic              i_comp_en,
  input  logic [BG_DATA-1:0] i_exp_data,
  input  logic [ADDR_X-1:0] i_addr_x,
  input  logic [ADDR_Y-1:0] i_addr_y,
  input  logic [BG_DATA-1:0] i_mem_rdata,
  output logic              o_fail_flag,
  input  logic              i_shift_en,
  input  logic              i_si,
  output logic              o_so
);

`ifdef PMBIST_CHK_DIAG_EN
  localparam int unsigned DiagW = ADDR_X + ADDR_Y + BG_DATA;
`else
  localparam int unsigned DiagW = 0;
`endif
  localparam int unsigned ChainW = 1 + FAIL_CNT_W + DiagW;
  localparam int unsigned StW    = 1 + BG_DATA + ADDR_X + ADDR_Y;
  localparam int unsigned CntW   = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Compare pipeline: {valid, exp_data, addr_x, addr_y}, not gated by run after entry.
  logic [StW-1:0] stage_q [RD_LAT];
  logic [StW-1:0] stage_d [RD_LAT];

  always_comb begin
    stage_d[0] = {i_comp_en & i_mbist_run, i_exp_data, i_addr_x, i_addr_y};
    for (int unsigned s = 1; s < RD_LAT; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  logic              last_vld;
  logic [BG_DATA-1:0] last_exp;
  logic [ADDR_X-1:0] last_x;
  logic [ADDR_Y-1:0] last_y;
  logic              mismatch;

  assign {last_vld, last_exp, last_x, last_y} = stage_q[RD_LAT-1];
  assign mismatch = last_vld & (i_mem_rdata != last_exp);

  // Run edge detect and sequencing state.
  logic            run_q;
  logic            clear;
  state_e          state_q, state_d;
  logic [CntW-1:0] drain_q, drain_d;

  assign clear = i_mbist_run & ~run_q;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (i_mbist_run) state_d = StCheck;
      end
      StCheck: begin
        if (!i_mbist_run) begin
          state_d = StDrain;
          drain_d = CntW'(RD_LAT);
        end
      end
      StDrain: begin
        if (i_mbist_run) begin
          state_d = StCheck;
        end else begin
          drain_d = drain_q - CntW'(1);
          if (drain_d == '0) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q   <= 1'b0;
      state_q <= StIdle;
      drain_q <= '0;
    end else begin
      run_q   <= i_mbist_run;
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Results register doubles as the unload chain: bit 0 = fail_flag, then counter, then diag.
  logic [ChainW-1:0]     chain_q, chain_d;
  logic [FAIL_CNT_W-1:0] fail_cnt;
  logic                  shift_ok;

  assign fail_cnt = chain_q[FAIL_CNT_W:1];
  assign shift_ok = (state_q == StIdle) & i_shift_en & ~i_mbist_run;

  always_comb begin
    chain_d = chain_q;
    if (clear) begin
      chain_d = '0;
    end else if (mismatch) begin
      chain_d[0] = 1'b1;
      if (fail_cnt != '1) chain_d[FAIL_CNT_W:1] = fail_cnt + FAIL_CNT_W'(1);
`ifdef PMBIST_CHK_DIAG_EN
      // First fail after a clear is captured, later fails leave it frozen.
      if (!chain_q[0]) begin
        chain_d[ChainW-1:1+FAIL_CNT_W] = {i_mem_rdata ^ last_exp, last_y, last_x};
      end
`endif
    end else if (shift_ok) begin
      chain_d = {i_si, chain_q[ChainW-1:1]};
    end
  end

`ifndef PMBIST_CHK_DIAG_EN
  logic unused_addr;
  assign unused_addr = ^{last_x, last_y};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign o_fail_flag = chain_q[0];
  assign o_so        = chain_q[0];

endmodule

// File: tb/tb_pmbist_mem_checker.sv
// Scoreboard bench: two checkers (read latency 1 and 3) share controller stimulus; each has its
// own memory model that returns exp^err after its latency.
module tb_pmbist_mem_checker;

`ifdef PMBIST_CHK_DIAG_EN
  localparam int ChainW = 11;
`else
  localparam int ChainW = 5;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       run = 1'b0, comp = 1'b0, shift_en = 1'b0, si = 1'b0;
  logic [1:0] exp_d = '0, ax = '0, ay = '0, err = '0;
  logic [1:0] rd1 = '0, rd3a = '0, rd3b = '0, rd3c = '0;
  logic       flag1, flag3, so1, so3;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rd1  <= exp_d ^ err;
    rd3a <= exp_d ^ err;
    rd3b <= rd3a;
    rd3c <= rd3b;
  end

  pmbist_mem_checker #(
    .BG_DATA(2), .ADDR_X(2), .ADDR_Y(2), .RD_LAT(1), .FAIL_CNT_W(4)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .i_mbist_run(run), .i_comp_en(comp), .i_exp_data(exp_d),
    .i_addr_x(ax), .i_addr_y(ay), .i_mem_rdata(rd1), .o_fail_flag(flag1),
    .i_shift_en(shift_en), .i_si(si), .o_so(so1)
  );

  pmbist_mem_checker #(
    .BG_DATA(2), .ADDR_X(2), .ADDR_Y(2), .RD_LAT(3), .FAIL_CNT_W(4)
  ) u_dut3 (
    .clk(clk), .rstn(rstn), .i_mbist_run(run), .i_comp_en(comp), .i_exp_data(exp_d),
    .i_addr_x(ax), .i_addr_y(ay), .i_mem_rdata(rd3c), .o_fail_flag(flag3),
    .i_shift_en(shift_en), .i_si(si), .o_so(so3)
  );

  // sel: 0 flag of lat-1 dut, 1 flag of lat-3 dut, 2 so of lat-1 dut, 3 so of lat-3 dut
  typedef struct {
    int unsigned cyc;
    int          sel;
    logic        val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  logic done = 1'b0;

  function automatic logic obs(input int sel);
    case (sel)
      0:       return flag1;
      1:       return flag3;
      2:       return so1;
      default: return so3;
    endcase
  endfunction

  task automatic push(input int unsigned c, input int sel, input logic v, input string nm);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = v; e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: compares every entry due this cycle; when stimulus is done, anything left is missed.
  initial begin
    logic got;
    forever begin
      @(negedge clk);
      for (int i = int'(sb_q.size()) - 1; i >= 0; i--) begin
        if (sb_q[i].cyc <= cyc || done) begin
          got = obs(sb_q[i].sel);
          n_vec++;
          if (got !== sb_q[i].val || sb_q[i].cyc != cyc) begin
            n_mis++;
            $display("FAIL %s: dut%0d got %b required %b (due cycle %0d, now %0d)",
                     sb_q[i].name, sb_q[i].sel, got, sb_q[i].val, sb_q[i].cyc, cyc);
          end
          sb_q.delete(i);
        end
      end
    end
  end

  // Watchdog: stimulus must finish well before this bound.
  initial begin
    #100000;
    n_mis++;
    $display("FAIL timeout: stimulus did not complete (cycle %0d)", cyc);
    $finish;
  end

  task automatic step(input logic r, input logic c, input logic [1:0] e, input logic [1:0] x,
                      input logic [1:0] y, input logic [1:0] er, input logic sh,
                      input logic sv);
    run = r; comp = c; exp_d = e; ax = x; ay = y; err = er; shift_en = sh; si = sv;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  function automatic logic [ChainW-1:0] mk_chain(input logic f, input logic [3:0] c,
                                                 input logic [1:0] x, input logic [1:0] y,
                                                 input logic [1:0] xr);
    logic [10:0] full;
    full = {xr, y, x, c, f};
    return full[ChainW-1:0];
  endfunction

  // Unload whole chain LSB first, shifting in ones; one extra shift shows a shifted-in bit.
  task automatic unload(input logic [ChainW-1:0] exp_chain, input string nm);
    int unsigned c0;
    c0 = cyc;
    push(c0 + 1, 2, exp_chain[0], $sformatf("%s_so0", nm));
    push(c0 + 1, 3, exp_chain[0], $sformatf("%s_so0", nm));
    idle(1);
    for (int i = 1; i < ChainW; i++) begin
      push(c0 + i + 1, 2, exp_chain[i], $sformatf("%s_so%0d", nm, i));
      push(c0 + i + 1, 3, exp_chain[i], $sformatf("%s_so%0d", nm, i));
      step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    end
    push(c0 + ChainW + 1, 0, 1'b1, $sformatf("%s_shin", nm));
    push(c0 + ChainW + 1, 1, 1'b1, $sformatf("%s_shin", nm));
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    idle(2);
  endtask

  initial begin
    int unsigned n;
    #1 rstn = 1'b0;
    #1;
    n_vec++;
    if (flag1 !== 1'b0 || flag3 !== 1'b0 || so1 !== 1'b0 || so3 !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_state: flags %b%b so %b%b required all 0", flag1, flag3, so1, so3);
    end
    @(negedge clk);
    for (int s = 0; s < 4; s++) push(cyc + 1, s, 1'b0, "reset");
    idle(2);
    rstn = 1'b1;
    idle(2);

    // 1: good memory
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 2'(i), 2'(i >> 2), 2'(i + 1), 2'b00, 1'b0, 1'b0);
    push(cyc + 1, 0, 1'b0, "good_flag");
    push(cyc + 3, 1, 1'b0, "good_flag");
    idle(6);
    unload(mk_chain(1'b0, 4'h0, 2'b00, 2'b00, 2'b00), "good");

    // 2: single fail at x=2 y=1, exp=01, rdata=11
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    n = cyc;
    push(n + 1, 0, 1'b0, "single_pre");
    push(n + 2, 0, 1'b1, "single_rise");
    push(n + 3, 1, 1'b0, "single_pre");
    push(n + 4, 1, 1'b1, "single_rise");
    step(1'b1, 1'b1, 2'b01, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    idle(6);
    unload(mk_chain(1'b1, 4'h1, 2'b10, 2'b01, 2'b10), "single");

    // 3: saturation, 21 mismatches, first at x=3 y=0 xor=01
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b10, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 2'(i), 2'(i), 2'(i + 2), 2'b11, 1'b0, 1'b0);
    idle(6);
    unload(mk_chain(1'b1, 4'hF, 2'b11, 2'b00, 2'b01), "sat");

    // 4: mismatch on the last read before run falls; shift requests in CHECK/DRAIN ignored
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
    n = cyc;
    push(n + 1, 0, 1'b0, "drain_pre");
    push(n + 2, 0, 1'b1, "drain_rise");
    push(n + 3, 1, 1'b0, "drain_pre");
    push(n + 4, 1, 1'b1, "drain_rise");
    step(1'b1, 1'b1, 2'b11, 2'b01, 2'b11, 2'b11, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    idle(5);
    unload(mk_chain(1'b1, 4'h1, 2'b01, 2'b11, 2'b11), "drain");

    // 5: failing run, then restart clears; shift_en during run has no effect
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b01, 2'b00, 2'b10, 2'b01, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    idle(5);
    push(cyc + 1, 0, 1'b1, "restart_before");
    push(cyc + 1, 1, 1'b1, "restart_before");
    idle(1);
    n = cyc;
    for (int k = 1; k <= 4; k++) begin
      push(n + k, 0, 1'b0, "restart_clr");
      push(n + k, 1, 1'b0, "restart_clr");
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
    idle(6);
    unload(mk_chain(1'b0, 4'h0, 2'b00, 2'b00, 2'b00), "restart");

    // 6: async reset mid-CHECK with fail_flag set
    step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    n = cyc;
    push(n + 4, 0, 1'b1, "arst_pre");
    push(n + 4, 1, 1'b1, "arst_pre");
    step(1'b1, 1'b1, 2'b10, 2'b01, 2'b01, 2'b11, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    n = cyc;
    push(n + 1, 0, 1'b0, "arst_async");
    push(n + 1, 1, 1'b0, "arst_async");
    run = 1'b1; comp = 1'b1; exp_d = 2'b00; err = 2'b11;
    @(posedge clk);
    #1 rstn = 1'b0;
    run = 1'b0; comp = 1'b0; err = 2'b00;
    #1;
    n_vec++;
    if (flag1 !== 1'b0 || flag3 !== 1'b0) begin
      n_mis++;
      $display("FAIL arst_immediate: flags %b%b required 00 without a clk edge", flag1, flag3);
    end
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      push(cyc + k, 0, 1'b0, "arst_empty");
      push(cyc + k, 1, 1'b0, "arst_empty");
    end
    rstn = 1'b1;
    idle(7);

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
